// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one pipelined adder among NUM_REQ requesters; results return tagged with the requester ID.
// Latency: handshake to rsp_valid is ADD_LAT+1 edges; results carry no backpressure.
module adder_share_arbiter #(
    parameter int INP_DW  = 3,
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 1,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*INP_DW-1:0] req_a,
    input  logic [NUM_REQ*INP_DW-1:0] req_b,
    output logic [INP_DW-1:0]         add_inp1,
    output logic [INP_DW-1:0]         add_inp2,
    input  logic [INP_DW:0]           add_outp,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [INP_DW:0]           rsp_data,
    output logic                      busy
);

    logic [ID_W-1:0]   ptr;
    logic              grant_any;
    logic [ID_W-1:0]   grant_id;
    logic [INP_DW-1:0] sel_a;
    logic [INP_DW-1:0] sel_b;
    logic [ADD_LAT:0]  tag_vld;
    logic [ID_W-1:0]   tag_id [ADD_LAT+1];

    // Search begins one past the last winner, so the last winner has lowest priority.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(ptr) + k) % NUM_REQ;
            cand = idx[ID_W-1:0];
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
        if (rst || flush) begin
            grant_any = 1'b0;
        end
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                sel_a = req_a[i*INP_DW +: INP_DW];
                sel_b = req_b[i*INP_DW +: INP_DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_inp1  <= '0;
            add_inp2  <= '0;
            ptr       <= ID_W'(NUM_REQ - 1);
            tag_vld   <= '0;
            for (int i = 0; i <= ADD_LAT; i++) begin
                tag_id[i] <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            if (grant_any) begin
                add_inp1 <= sel_a;
                add_inp2 <= sel_b;
                ptr      <= grant_id;
            end else begin
                add_inp1 <= '0;
                add_inp2 <= '0;
            end
            tag_vld[0] <= grant_any;
            tag_id[0]  <= grant_id;
            for (int i = 1; i <= ADD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
            // The last tag stage lines up with add_outp holding that tag's sum.
            rsp_valid <= tag_vld[ADD_LAT] && !flush;
            if (tag_vld[ADD_LAT] && !flush) begin
                rsp_id   <= tag_id[ADD_LAT];
                rsp_data <= add_outp;
            end
            if (flush) begin
                tag_vld <= '0;
            end
        end
    end

    assign busy = (|tag_vld) | rsp_valid;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter with a one-stage adder model; responses checked against a scoreboard queue.
module tb_adder_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_a;
    logic [11:0] req_b;
    logic [2:0]  add_inp1;
    logic [2:0]  add_inp2;
    logic [3:0]  add_outp = 4'd0;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic        busy;

    typedef struct {
        int id;
        int data;
        int due;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    logic [2:0] a_v [4];
    logic [2:0] b_v [4];

    adder_share_arbiter #(.INP_DW(3), .NUM_REQ(4), .ADD_LAT(1), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_inp1(add_inp1), .add_inp2(add_inp2), .add_outp(add_outp),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        add_outp <= {1'b0, add_inp1} + {1'b0, add_inp2};
        cyc++;
    end

    // Response monitor: every rsp_valid must match the queue head, on its due cycle.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_rsp id=%0d data=%0d cyc=%0d", rsp_id, rsp_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (rsp_id !== 2'(mon_e.id) || rsp_data !== 4'(mon_e.data) || cyc != mon_e.due)
                    $display("FAIL rsp got id=%0d data=%0d cyc=%0d want id=%0d data=%0d cyc=%0d",
                             rsp_id, rsp_data, cyc, mon_e.id, mon_e.data, mon_e.due);
                else
                    passes++;
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            mon_e = sb.pop_front();
            $display("FAIL missing_rsp got none want id=%0d data=%0d at cyc=%0d", mon_e.id, mon_e.data, mon_e.due);
        end
    end

    task automatic step(input logic [3:0] v, input logic fl);
        @(posedge clk);
        #1;
        req_valid = v;
        flush     = fl;
        req_a     = {a_v[3], a_v[2], a_v[1], a_v[0]};
        req_b     = {b_v[3], b_v[2], b_v[1], b_v[0]};
        @(negedge clk);
    endtask

    task automatic push(input int id);
        exp_t e;
        e.id   = id;
        e.data = int'(a_v[id]) + int'(b_v[id]);
        e.due  = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req_valid = 4'b1111; req_a = '0; req_b = '0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            add_inp1 !== 3'd0 || add_inp2 !== 3'd0 || rsp_id !== 2'd0 || rsp_data !== 4'd0)
            $display("FAIL reset_state got rdy=%b rv=%b busy=%b in1=%0d in2=%0d id=%0d data=%0d want all zero",
                     req_ready, rsp_valid, busy, add_inp1, add_inp2, rsp_id, rsp_data);
        else passes++;
        req_valid = 4'b0000;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        a_v[0] = 3'd3; b_v[0] = 3'd5;
        step(4'b0001, 1'b0);
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready);
        else passes++;
        push(0);
        step(4'b0000, 1'b0);
        checks++;
        if (add_inp1 !== 3'd3 || add_inp2 !== 3'd5 || busy !== 1'b1)
            $display("FAIL single_operands got %0d/%0d busy=%b want 3/5 busy=1", add_inp1, add_inp2, busy);
        else passes++;
        repeat (3) step(4'b0000, 1'b0);
    endtask

    task automatic test_max();
        a_v[3] = 3'd7; b_v[3] = 3'd7;
        step(4'b1000, 1'b0);
        checks++;
        if (req_ready !== 4'b1000) $display("FAIL max_ready got %b want 1000", req_ready);
        else passes++;
        push(3);
        a_v[3] = 3'd0; b_v[3] = 3'd0;
        step(4'b1000, 1'b0);
        checks++;
        if (req_ready !== 4'b1000) $display("FAIL zero_ready got %b want 1000", req_ready);
        else passes++;
        push(3);
        repeat (4) step(4'b0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            a_v[i] = 3'(i); b_v[i] = 3'd1;
        end
        for (int c = 0; c < 8; c++) begin
            step(4'b1111, 1'b0);
            checks++;
            if (req_ready !== (4'b0001 << (c % 4)))
                $display("FAIL b2b_ready c=%0d got %b want %b", c, req_ready, 4'b0001 << (c % 4));
            else passes++;
            push(c % 4);
        end
        repeat (4) step(4'b0000, 1'b0);
    endtask

    task automatic test_rr_pair();
        int exp_g [7];
        logic [3:0] vv [7];
        exp_g = '{0, 2, 0, 2, 0, 0, 0};
        vv    = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b0001, 4'b0001};
        a_v[0] = 3'd1; b_v[0] = 3'd2; a_v[2] = 3'd6; b_v[2] = 3'd5;
        step(4'b0100, 1'b0);
        checks++;
        if (req_ready !== 4'b0100) $display("FAIL rr_first got %b want 0100", req_ready);
        else passes++;
        push(2);
        for (int c = 0; c < 7; c++) begin
            step(vv[c], 1'b0);
            checks++;
            if (req_ready !== (4'b0001 << exp_g[c]))
                $display("FAIL rr_pair c=%0d got %b want %b", c, req_ready, 4'b0001 << exp_g[c]);
            else passes++;
            push(exp_g[c]);
        end
        repeat (4) step(4'b0000, 1'b0);
    endtask

    task automatic test_reset_mid();
        a_v[0] = 3'd4; b_v[0] = 3'd2; a_v[1] = 3'd1; b_v[1] = 3'd1;
        step(4'b0011, 1'b0);
        checks++;
        if (req_ready !== 4'b0010) $display("FAIL mid_g1 got %b want 0010", req_ready);
        else passes++;
        step(4'b0011, 1'b0);
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL mid_g2 got %b want 0001", req_ready);
        else passes++;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || add_inp1 !== 3'd0 || add_inp2 !== 3'd0 || req_ready !== 4'b0000)
            $display("FAIL mid_reset got rv=%b busy=%b in1=%0d in2=%0d rdy=%b want 0/0/0/0/0000",
                     rsp_valid, busy, add_inp1, add_inp2, req_ready);
        else passes++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL mid_release got %b want 0001", req_ready);
        else passes++;
        push(0);
        repeat (4) step(4'b0000, 1'b0);
    endtask

    task automatic test_flush();
        a_v[2] = 3'd3; b_v[2] = 3'd6;
        step(4'b0100, 1'b0);
        checks++;
        if (req_ready !== 4'b0100) $display("FAIL flush_pre got %b want 0100", req_ready);
        else passes++;
        step(4'b0100, 1'b1);
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b1)
            $display("FAIL flush_cycle got rdy=%b busy=%b want 0000/1", req_ready, busy);
        else passes++;
        step(4'b0100, 1'b0);
        checks++;
        if (req_ready !== 4'b0100 || busy !== 1'b0)
            $display("FAIL flush_after got rdy=%b busy=%b want 0100/0", req_ready, busy);
        else passes++;
        push(2);
        repeat (4) step(4'b0000, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            a_v[i] = 3'd0; b_v[i] = 3'd0;
        end
        test_reset();
        test_single();
        test_max();
        test_back_to_back();
        test_rr_pair();
        test_reset_mid();
        test_flush();
        checks++;
        if (sb.size() != 0) $display("FAIL drain got %0d pending want 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
